fuzzy_stage_scheduler: RTL and testbench



---
 rtl/fuzzy_stage_scheduler_pkg.sv | 16 +
 rtl/fuzzy_stage_scheduler_prescaler.sv | 28 ++
 rtl/fuzzy_stage_scheduler.sv | 135 +++++++++++++
 tb/tb_fuzzy_stage_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_stage_scheduler_pkg.sv
// Shared types and default sizing for the fuzzy-controller stage scheduler.
package fuzzy_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    WAIT_DONE,
    FINISH,
    ERROR
  } sched_state_e;

  localparam int NUM_STAGES_DEF = 4;
  localparam int DIV_W_DEF      = 4;
  localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/fuzzy_stage_scheduler_prescaler.sv
// Clear-able up-counter that raises tick on the cycle it equals the limit.
// It parks at the limit, so it never wraps for any limit value.
module sched_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fuzzy_stage_scheduler.sv
// Issues one enable strobe per pipeline stage in order, spaced by a
// programmable prescaler, and flags a stage that misses its done window.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_TICK | prescaler gap before issuing the current stage
// WAIT_DONE | strobe issued, waiting for stage_done[cur_stage]
// FINISH    | one-cycle done pulse
// ERROR     | stage timed out, held until err_clr
module fuzzy_stage_scheduler
  import fuzzy_sched_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DIV_W-1:0]      i_div_cfg,
  input  logic                  i_err_clr,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [SW-1:0]         o_cur_stage,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  sched_state_e r_state, w_next;
  logic [SW-1:0]         r_cur, w_next_cur;
  logic [TW-1:0]         r_tcnt;
  logic [DIV_W-1:0]      r_div_q;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_busy, r_done, r_err;
  logic                  w_clr, w_tick, w_cur_done;

  assign w_cur_done = i_stage_done[r_cur];

  sched_prescaler #(.W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (r_state == WAIT_TICK),
    .i_limit (r_div_q),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next     = r_state;
    w_next_cur = r_cur;
    w_clr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next     = WAIT_TICK;
          w_next_cur = '0;
          w_clr      = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (w_tick) w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving in the final timeout cycle still counts.
        if (w_cur_done) begin
          if (r_cur == LAST_STAGE) begin
            w_next = FINISH;
          end else begin
            w_next     = WAIT_TICK;
            w_next_cur = r_cur + 1'b1;
            w_clr      = 1'b1;
          end
        end else if (r_tcnt == TO_LAST) begin
          w_next = ERROR;
        end
      end
      FINISH: begin
        w_next     = IDLE;
        w_next_cur = '0;
      end
      ERROR: begin
        if (i_err_clr) begin
          w_next     = IDLE;
          w_next_cur = '0;
        end
      end
      default: begin
        w_next     = IDLE;
        w_next_cur = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_tcnt     <= '0;
      r_div_q    <= '0;
      r_stage_en <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cur   <= w_next_cur;
      if (r_state == IDLE && i_start) r_div_q <= i_div_cfg;
      if (r_state == WAIT_TICK) begin
        r_tcnt <= '0;
      end else if (r_state == WAIT_DONE) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      // Outputs are registered from the next state so they align with it.
      r_stage_en <= (r_state == WAIT_TICK && w_tick) ?
                    (NUM_STAGES'(1) << r_cur) : '0;
      r_busy     <= (w_next == WAIT_TICK) || (w_next == WAIT_DONE) ||
                    (w_next == FINISH);
      r_done     <= (w_next == FINISH);
      r_err      <= (w_next == ERROR);
    end
  end

  assign o_stage_en  = r_stage_en;
  assign o_cur_stage = r_cur;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_fuzzy_stage_scheduler.sv
// Directed bench for fuzzy_stage_scheduler; cycle 0 is the cycle start is driven.
module tb_fuzzy_stage_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [3:0] i_div_cfg;
  logic       i_err_clr;
  logic [3:0] i_stage_done;
  logic [3:0] o_stage_en;
  logic [1:0] o_cur_stage;
  logic       o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;

  int         s_cyc[8];
  logic [3:0] s_val[8];
  int         n_strobe, done_cyc, n_done, busy_first, busy_last, n_busy, err_cyc;

  always #5 clk = ~clk;

  fuzzy_stage_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_div_cfg    (i_div_cfg),
    .i_err_clr    (i_err_clr),
    .i_stage_done (i_stage_done),
    .o_stage_en   (o_stage_en),
    .o_cur_stage  (o_cur_stage),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // Responder: stage k answers lat cycles after its strobe (0 = same cycle),
  // except mute_stage which never answers.
  task automatic run_seq(input logic [3:0] div, input int lat, input int mute_stage,
                         input int ncyc, input int stray_cyc,
                         input int chg_cyc, input logic [3:0] chg_val);
    int pend_stage, pend_cyc, idx;
    i_div_cfg = div;
    i_start = 1'b1;
    pend_stage = -1; pend_cyc = 0;
    n_strobe = 0; done_cyc = -1; n_done = 0;
    busy_first = -1; busy_last = -1; n_busy = 0; err_cyc = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_stage_done = '0;
      if (c == chg_cyc) i_div_cfg = chg_val;
      if (o_stage_en != 4'b0000) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (o_stage_en[k]) idx = k;
        if (n_strobe < 8) begin
          s_cyc[n_strobe] = c;
          s_val[n_strobe] = o_stage_en;
        end
        n_strobe++;
        if (idx != mute_stage) begin
          pend_stage = idx;
          pend_cyc = c + lat;
        end
      end
      if (pend_stage >= 0 && c == pend_cyc) begin
        i_stage_done[pend_stage] = 1'b1;
        pend_stage = -1;
      end
      if (c == stray_cyc) i_stage_done[3] = 1'b1;
      if (o_done) begin done_cyc = c; n_done++; end
      if (o_busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        n_busy++;
      end
      if (o_err && err_cyc < 0) err_cyc = c;
    end
    i_stage_done = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_div_cfg = '0; i_err_clr = 1'b0; i_stage_done = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_stage_en, o_cur_stage, o_busy, o_done, o_err} !== 9'b0)
      begin errors++; $display("FAIL reset_outputs got=%b want=0", {o_stage_en, o_cur_stage, o_busy, o_done, o_err}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fast_path();
    int exp_c[4] = '{2, 4, 6, 8};
    logic [3:0] exp_v;
    run_seq(4'd0, 0, -1, 14, -1, -1, 4'd0);
    checks++;
    if (n_strobe !== 4) begin errors++; $display("FAIL fast_nstrobe got=%0d want=4", n_strobe); end
    for (int k = 0; k < 4; k++) begin
      exp_v = 4'b0001 << k;
      checks++;
      if (s_cyc[k] !== exp_c[k] || s_val[k] !== exp_v)
        begin errors++; $display("FAIL fast_strobe%0d got cyc=%0d en=%b want cyc=%0d en=%b", k, s_cyc[k], s_val[k], exp_c[k], exp_v); end
    end
    checks++;
    if (done_cyc !== 9 || n_done !== 1) begin errors++; $display("FAIL fast_done got cyc=%0d n=%0d want cyc=9 n=1", done_cyc, n_done); end
    checks++;
    if (busy_first !== 1 || busy_last !== 9 || n_busy !== 9)
      begin errors++; $display("FAIL fast_busy got first=%0d last=%0d n=%0d want 1/9/9", busy_first, busy_last, n_busy); end
  endtask

  task automatic test_prescale();
    int exp_c[4] = '{5, 11, 17, 23};
    run_seq(4'd3, 1, -1, 32, -1, -1, 4'd0);
    checks++;
    if (n_strobe !== 4) begin errors++; $display("FAIL pre_nstrobe got=%0d want=4", n_strobe); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_cyc[k] !== exp_c[k]) begin errors++; $display("FAIL pre_strobe%0d got=%0d want=%0d", k, s_cyc[k], exp_c[k]); end
    end
    checks++;
    if (done_cyc !== 25 || n_done !== 1 || busy_last !== 25)
      begin errors++; $display("FAIL pre_done got cyc=%0d n=%0d busy_last=%0d want 25/1/25", done_cyc, n_done, busy_last); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL pre_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_timeout();
    run_seq(4'd0, 0, 2, 30, -1, -1, 4'd0);
    checks++;
    if (n_strobe !== 3 || s_cyc[2] !== 6) begin errors++; $display("FAIL to_strobes got n=%0d s2=%0d want 3/6", n_strobe, s_cyc[2]); end
    checks++;
    if (err_cyc !== 22 || busy_last !== 21 || n_done !== 0)
      begin errors++; $display("FAIL to_entry got err=%0d busy_last=%0d done=%0d want 22/21/0", err_cyc, busy_last, n_done); end
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_cur_stage !== 2'd2)
      begin errors++; $display("FAIL to_hold got err=%b busy=%b cur=%0d want 1/0/2", o_err, o_busy, o_cur_stage); end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_stage_en !== 4'b0 || o_cur_stage !== 2'd2)
      begin errors++; $display("FAIL to_start_ignored got err=%b busy=%b en=%b cur=%0d want 1/0/0000/2", o_err, o_busy, o_stage_en, o_cur_stage); end
    i_err_clr = 1'b1;
    @(posedge clk); #1;
    i_err_clr = 1'b0;
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b0 || o_cur_stage !== 2'd0)
      begin errors++; $display("FAIL to_clear got err=%b busy=%b cur=%0d want 0/0/0", o_err, o_busy, o_cur_stage); end
  endtask

  task automatic test_race();
    int exp_c[4] = '{2, 19, 36, 53};
    run_seq(4'd0, 15, -1, 75, 25, -1, 4'd0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_cyc[k] !== exp_c[k]) begin errors++; $display("FAIL race_strobe%0d got=%0d want=%0d", k, s_cyc[k], exp_c[k]); end
    end
    checks++;
    if (err_cyc !== -1 || done_cyc !== 69 || n_done !== 1 || n_strobe !== 4)
      begin errors++; $display("FAIL race_done got err=%0d done=%0d n=%0d strobes=%0d want -1/69/1/4", err_cyc, done_cyc, n_done, n_strobe); end
  endtask

  task automatic test_reset_midrun();
    run_seq(4'd0, 3, -1, 7, -1, -1, 4'd0);
    checks++;
    if (o_stage_en !== 4'b0010 || o_busy !== 1'b1 || o_cur_stage !== 2'd1)
      begin errors++; $display("FAIL rst_pre got en=%b busy=%b cur=%0d want 0010/1/1", o_stage_en, o_busy, o_cur_stage); end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_stage_en, o_cur_stage, o_busy, o_done, o_err} !== 9'b0)
      begin errors++; $display("FAIL rst_async got=%b want=0", {o_stage_en, o_cur_stage, o_busy, o_done, o_err}); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_done || o_busy) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL rst_quiet got active_cycles=%0d want=0", n_done); end
    run_seq(4'd0, 0, -1, 14, -1, -1, 4'd0);
    checks++;
    if (n_strobe !== 4 || s_cyc[0] !== 2 || s_cyc[3] !== 8 || done_cyc !== 9)
      begin errors++; $display("FAIL rst_rerun got n=%0d s0=%0d s3=%0d done=%0d want 4/2/8/9", n_strobe, s_cyc[0], s_cyc[3], done_cyc); end
  endtask

  task automatic test_config_isolation();
    int exp_a[4] = '{4, 8, 12, 16};
    run_seq(4'd2, 0, -1, 22, -1, 6, 4'd7);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_cyc[k] !== exp_a[k]) begin errors++; $display("FAIL cfg_strobe%0d got=%0d want=%0d", k, s_cyc[k], exp_a[k]); end
    end
    checks++;
    if (done_cyc !== 17) begin errors++; $display("FAIL cfg_done got=%0d want=17", done_cyc); end
    run_seq(4'd7, 0, -1, 42, -1, -1, 4'd0);
    checks++;
    if (s_cyc[0] !== 9 || s_cyc[1] !== 18 || s_cyc[3] !== 36 || done_cyc !== 37)
      begin errors++; $display("FAIL cfg_next got s0=%0d s1=%0d s3=%0d done=%0d want 9/18/36/37", s_cyc[0], s_cyc[1], s_cyc[3], done_cyc); end
  endtask

  initial begin
    test_reset();
    test_fast_path();
    test_prescale();
    test_timeout();
    test_race();
    test_reset_midrun();
    test_config_isolation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
